regfile: RTL and testbench

- Architectural register file: 32 x 32-bit GPRs plus the HI/LO pair.
- Sits at the consumer end of the write-back path: it takes the WB-stage write port (target address, write enable, write data) driven by the MEM/WB pipeline register.
- Serves two combinational read ports to the ID stage, with write-to-read bypass so a WB-stage write is visible to a same-cycle ID read.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_hilo_reg.sv | 42 ++++
 rtl/regfile.sv | 70 +++++++
 tb/tb_regfile.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and bus types used by the write-back path and ID-stage read ports.
package regfile_pkg;

  localparam int RegWidth   = 32;
  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;

  typedef logic [RegNumLog2-1:0] reg_addr_bus_t;
  typedef logic [RegWidth-1:0]   reg_bus_t;

  localparam reg_addr_bus_t NOPRegAddr = 5'b0;
  localparam reg_bus_t      ZeroWord   = 32'h0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;
  localparam logic RstEnable    = 1'b1;

endpackage

// File: rtl/regfile_hilo_reg.sv
// HI/LO register pair: written together on whilo, outputs bypass the incoming pair
// in the write cycle so consumers see the new value with zero added latency.
module hilo_reg
  import regfile_pkg::*;
#(
  parameter int DATA_W = RegWidth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (whilo == WriteEnable) begin
      r_hi <= hi_i;
      r_lo <= lo_i;
    end
  end

  always_comb begin
    hi_o = r_hi;
    lo_o = r_lo;
    if (rst == RstEnable) begin
      hi_o = '0;
      lo_o = '0;
    end else if (whilo == WriteEnable) begin
      hi_o = hi_i;
      lo_o = lo_i;
    end
  end

endmodule

// File: rtl/regfile.sv
// Architectural GPR file (r0 hardwired to zero) plus HI/LO; one WB write port and
// two combinational ID read ports with same-cycle write-to-read bypass.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RegWidth,
  parameter int ADDR_W   = RegNumLog2,
  parameter int NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] r_regs [0:NUM_REGS-1];
  logic              w_wr;

  // we is tested first so an unknown waddr with we=0 can never reach the array
  assign w_wr = (we == WriteEnable) && (waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (rst == RstEnable)                                    rdata1 = '0;
    else if (raddr1 == '0)                                   rdata1 = '0;
    else if (re1 == ReadEnable && we == WriteEnable && raddr1 == waddr) rdata1 = wdata;
    else if (re1 == ReadEnable)                              rdata1 = r_regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (rst == RstEnable)                                    rdata2 = '0;
    else if (raddr2 == '0)                                   rdata2 = '0;
    else if (re2 == ReadEnable && we == WriteEnable && raddr2 == waddr) rdata2 = wdata;
    else if (re2 == ReadEnable)                              rdata2 = r_regs[raddr2];
  end

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk   (clk),
    .rst   (rst),
    .whilo (whilo),
    .hi_i  (hi_i),
    .lo_i  (lo_i),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

endmodule

// File: tb/tb_regfile.sv
// Directed vector bench for regfile: table of per-cycle stimulus with expected
// pre-edge outputs, plus hand sequences for reset behaviour.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        whilo;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .whilo  (whilo),
    .hi_i   (hi_i),
    .lo_i   (lo_i),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; waddr = 5'd0; wdata = 32'h0;
    re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
    whilo = 1'b0; hi_i = 32'h0; lo_i = 32'h0;
  endtask

  task automatic add(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic r1, input logic [4:0] a1, input logic r2, input logic [4:0] a2,
                     input logic hl, input logic [31:0] h, input logic [31:0] l,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.re1 = r1; v.raddr1 = a1;
    v.re2 = r2; v.raddr2 = a2; v.whilo = hl; v.hi = h; v.lo = l;
    v.exp1 = e1; v.exp2 = e2; v.exp_hi = eh; v.exp_lo = el;
    vecs.push_back(v);
  endtask

  initial begin
    logic [4:0] xaddr;
    xaddr = 5'bx;

    //   we wa  wdata         re1 a1  re2 a2  hl hi     lo     exp1          exp2          hi     lo
    add(1, 3,  32'h12345678, 1,  3,  1,  4,  0, 32'h0, 32'h0, 32'h12345678, 32'h0,        32'h0, 32'h0);
    add(0, 0,  32'h0,        1,  3,  1,  4,  0, 32'h0, 32'h0, 32'h12345678, 32'h0,        32'h0, 32'h0);
    add(1, 7,  32'hCAFEF00D, 1,  7,  1,  7,  0, 32'h0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 32'h0);
    add(0, 7,  32'h0,        1,  7,  1,  7,  0, 32'h0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 32'h0);
    add(1, 0,  32'hFFFFFFFF, 1,  0,  0,  3,  0, 32'h0, 32'h0, 32'h0,        32'h0,        32'h0, 32'h0);
    add(0, 0,  32'h0,        1,  0,  1,  3,  0, 32'h0, 32'h0, 32'h0,        32'h12345678, 32'h0, 32'h0);
    add(0, 0,  32'h0,        1,  7,  0,  7,  1, 32'h1, 32'h2, 32'hCAFEF00D, 32'h0,        32'h1, 32'h2);
    add(0, 0,  32'h0,        0,  7,  0,  0,  0, 32'hFF,32'hEE,32'h0,        32'h0,        32'h1, 32'h2);
    add(0, 0,  32'h0,        0,  0,  0,  0,  0, 32'h0, 32'h0, 32'h0,        32'h0,        32'h1, 32'h2);
    add(1, 9,  32'hA,        1,  9,  1,  9,  0, 32'h0, 32'h0, 32'hA,        32'hA,        32'h1, 32'h2);
    add(1, 9,  32'hB,        0,  9,  1,  9,  0, 32'h0, 32'h0, 32'h0,        32'hB,        32'h1, 32'h2);
    add(0, 9,  32'hC,        1,  9,  1,  9,  0, 32'h0, 32'h0, 32'hB,        32'hB,        32'h1, 32'h2);
    add(0, xaddr, 32'h55555555, 1, 3, 1, 7, 0, 32'h0, 32'h0, 32'h12345678, 32'hCAFEF00D, 32'h1, 32'h2);
    add(0, 0,  32'h0,        1,  3,  0,  9,  0, 32'h0, 32'h0, 32'h12345678, 32'h0,        32'h1, 32'h2);

    idle();
    rst = 1'b1;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;
    whilo = 1'b1; hi_i = 32'h77; lo_i = 32'h88;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata1", rdata1, 32'h0);
    chk("reset_rdata2", rdata2, 32'h0);
    chk("reset_hi", hi_o, 32'h0);
    chk("reset_lo", lo_o, 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      re1 = vecs[i].re1; raddr1 = vecs[i].raddr1;
      re2 = vecs[i].re2; raddr2 = vecs[i].raddr2;
      whilo = vecs[i].whilo; hi_i = vecs[i].hi; lo_i = vecs[i].lo;
      #2;
      chk($sformatf("v%0d_rdata1", i), rdata1, vecs[i].exp1);
      chk($sformatf("v%0d_rdata2", i), rdata2, vecs[i].exp2);
      chk($sformatf("v%0d_hi", i), hi_o, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo_o, vecs[i].exp_lo);
    end

    // Mid-run asynchronous reset after writing r5
    @(negedge clk);
    idle();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    @(negedge clk);
    idle();
    re1 = 1'b1; raddr1 = 5'd5;
    #1;
    chk("r5_written", rdata1, 32'hDEADBEEF);
    #1;
    rst = 1'b1;
    #1;
    chk("r5_in_reset", rdata1, 32'h0);
    chk("hi_cleared_async", hi_o, 32'h0);
    // A write presented while reset is held must be discarded
    we = 1'b1; waddr = 5'd6; wdata = 32'h13579BDF;
    whilo = 1'b1; hi_i = 32'h99; lo_i = 32'hAA;
    #1;
    chk("rdata1_in_reset_wr", rdata1, 32'h0);
    chk("hi_bypass_in_reset", hi_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd6;
    #1;
    chk("r5_after_reset", rdata1, 32'h0);
    chk("r6_write_in_reset", rdata2, 32'h0);
    chk("hi_after_reset", hi_o, 32'h0);
    chk("lo_after_reset", lo_o, 32'h0);
    raddr1 = 5'd9; raddr2 = 5'd7;
    #1;
    chk("r9_after_reset", rdata1, 32'h0);
    chk("r7_after_reset", rdata2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
